dot_acc_sequencer: RTL and testbench

Sequences the 24-input compressor tree to reduce dot products longer than one beat. Each beat is 24 signed partial products. The block accepts a job of `len_i` beats and reduces each beat to sum/carry in the tree. It accumulates the result into a signed accumulator and returns the final value over a valid/ready handshake. It sits between the partial-product generator and the AI core's result writeback.

---
 rtl/dot_acc_pkg.sv | 17 +
 rtl/compressor_24_2.sv | 25 ++
 rtl/dot_acc_sequencer.sv | 168 ++++++++++++++++
 tb/tb_dot_acc_sequencer.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dot_acc_pkg.sv
// Shared types and default widths for the dot-product accumulate sequencer.
// Optional sum/carry pipeline stage is enabled with DOT_ACC_PIPE_EN.
package dot_acc_pkg;

    localparam int DOT_IN_SIZE   = 12;
    localparam int DOT_TREE_SIZE = 20;
    localparam int DOT_ACC_SIZE  = 32;
    localparam int DOT_BEAT_N    = 24;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/compressor_24_2.sv
// Reduces one beat of 24 signed partial products to a sum/carry pair.
// Each output carries a half-beat total so both sign-extend exactly downstream.
module compressor_24_2
    import dot_acc_pkg::*;
#(
    parameter int IN_SIZE   = DOT_IN_SIZE,
    parameter int TREE_SIZE = DOT_TREE_SIZE
)(
    input  logic signed [IN_SIZE-1:0]   in_i [0:DOT_BEAT_N-1],
    output logic        [TREE_SIZE-1:0] sum_o,
    output logic        [TREE_SIZE-1:0] carry_o
);

    localparam int HALF = DOT_BEAT_N / 2;

    always_comb begin
        sum_o   = '0;
        carry_o = '0;
        for (int k = 0; k < HALF; k++) begin
            sum_o   = sum_o + TREE_SIZE'(in_i[k]);
            carry_o = carry_o + TREE_SIZE'(in_i[k+HALF]);
        end
    end

endmodule

// File: rtl/dot_acc_sequencer.sv
// Multi-beat dot-product accumulator around the 24:2 compressor tree.
// Define DOT_ACC_PIPE_EN to register sum/carry ahead of the accumulator.
module dot_acc_sequencer
    import dot_acc_pkg::*;
#(
    parameter int IN_SIZE   = DOT_IN_SIZE,
    parameter int TREE_SIZE = DOT_TREE_SIZE,
    parameter int ACC_SIZE  = DOT_ACC_SIZE,
    parameter int LEN_W     = 8
)(
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      start_i,
    input  logic [LEN_W-1:0]          len_i,
    output logic                      busy_o,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic signed [IN_SIZE-1:0] in_i [0:DOT_BEAT_N-1],
    output logic                      res_valid_o,
    input  logic                      res_ready_i,
    output logic [ACC_SIZE-1:0]       res_o,
    output logic                      ovf_o
);

    if (ACC_SIZE < TREE_SIZE) begin : g_size_chk
        $error("ACC_SIZE must be >= TREE_SIZE");
    end

    state_e              state_q, state_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic [ACC_SIZE-1:0] acc_q, acc_d;
    logic                ovf_q, ovf_d;

    logic [TREE_SIZE-1:0] tree_sum, tree_carry;
    logic [TREE_SIZE-1:0] add_sum, add_carry;
    logic                 add_en;
    logic                 beat_acc, last_beat;

    logic [ACC_SIZE-1:0] sum_ext, carry_ext;
    logic [ACC_SIZE-1:0] acc1, acc2;
    logic                ov1, ov2;

    compressor_24_2 #(
        .IN_SIZE  (IN_SIZE),
        .TREE_SIZE(TREE_SIZE)
    ) u_tree (
        .in_i   (in_i),
        .sum_o  (tree_sum),
        .carry_o(tree_carry)
    );

    assign beat_acc  = in_valid_i && (state_q == ST_ACCUM);
    assign last_beat = beat_acc && (cnt_q == len_q - LEN_W'(1));

`ifdef DOT_ACC_PIPE_EN
    logic [TREE_SIZE-1:0] pipe_sum_q, pipe_sum_d;
    logic [TREE_SIZE-1:0] pipe_carry_q, pipe_carry_d;
    logic                 pipe_v_q, pipe_v_d;

    assign pipe_v_d     = beat_acc;
    assign pipe_sum_d   = beat_acc ? tree_sum : pipe_sum_q;
    assign pipe_carry_d = beat_acc ? tree_carry : pipe_carry_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pipe_v_q     <= 1'b0;
            pipe_sum_q   <= '0;
            pipe_carry_q <= '0;
        end else begin
            pipe_v_q     <= pipe_v_d;
            pipe_sum_q   <= pipe_sum_d;
            pipe_carry_q <= pipe_carry_d;
        end
    end

    assign add_en    = pipe_v_q;
    assign add_sum   = pipe_sum_q;
    assign add_carry = pipe_carry_q;
`else
    assign add_en    = beat_acc;
    assign add_sum   = tree_sum;
    assign add_carry = tree_carry;
`endif

    // Two-step add so overflow is judged on each partial addition.
    assign sum_ext   = ACC_SIZE'($signed(add_sum));
    assign carry_ext = ACC_SIZE'($signed(add_carry));
    assign acc1      = acc_q + sum_ext;
    assign acc2      = acc1 + carry_ext;
    assign ov1 = (acc_q[ACC_SIZE-1] == sum_ext[ACC_SIZE-1])
              && (acc1[ACC_SIZE-1] != acc_q[ACC_SIZE-1]);
    assign ov2 = (acc1[ACC_SIZE-1] == carry_ext[ACC_SIZE-1])
              && (acc2[ACC_SIZE-1] != acc1[ACC_SIZE-1]);

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;

        if (add_en) begin
            acc_d = acc2;
            ovf_d = ovf_q | ov1 | ov2;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    acc_d = '0;
                    ovf_d = 1'b0;
                    cnt_d = '0;
                    if (len_i == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        len_d   = len_i;
                        state_d = ST_ACCUM;
                    end
                end
            end
            ST_ACCUM: begin
                if (beat_acc) begin
                    cnt_d = cnt_q + LEN_W'(1);
                    if (last_beat) begin
`ifdef DOT_ACC_PIPE_EN
                        state_d = ST_DRAIN;
`else
                        state_d = ST_DONE;
`endif
                    end
                end
            end
`ifdef DOT_ACC_PIPE_EN
            ST_DRAIN: state_d = ST_DONE;
`endif
            ST_DONE: begin
                if (res_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy_o      = (state_q != ST_IDLE);
    assign in_ready_o  = (state_q == ST_ACCUM);
    assign res_valid_o = (state_q == ST_DONE);
    assign res_o       = acc_q;
    assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_dot_acc_sequencer.sv
// Directed bench for dot_acc_sequencer; a second 20-bit-accumulator
// instance shares the stimulus to exercise signed wrap and overflow.
module tb_dot_acc_sequencer;

`ifdef DOT_ACC_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic               clk = 1'b0;
    logic               rst_i = 1'b1;
    logic               start_i = 1'b0;
    logic [7:0]         len_i = '0;
    logic               in_valid_i = 1'b0;
    logic               res_ready_i = 1'b0;
    logic signed [11:0] in_d [0:23];

    logic        busy_o, in_ready_o, res_valid_o, ovf_o;
    logic [31:0] res_o;
    logic        busy2, in_ready2, res_valid2, ovf2;
    logic [19:0] res2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dot_acc_sequencer u_dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .len_i      (len_i),
        .busy_o     (busy_o),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .in_i       (in_d),
        .res_valid_o(res_valid_o),
        .res_ready_i(res_ready_i),
        .res_o      (res_o),
        .ovf_o      (ovf_o)
    );

    dot_acc_sequencer #(.ACC_SIZE(20)) u_ovf (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .len_i      (len_i),
        .busy_o     (busy2),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready2),
        .in_i       (in_d),
        .res_valid_o(res_valid2),
        .res_ready_i(res_ready_i),
        .res_o      (res2),
        .ovf_o      (ovf2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_all(input logic signed [11:0] v);
        for (int k = 0; k < 24; k++) in_d[k] = v;
    endtask

    task automatic start_job(input logic [7:0] n);
        start_i = 1'b1;
        len_i   = n;
        tick();
        start_i = 1'b0;
    endtask

    task automatic handshake();
        res_ready_i = 1'b1;
        tick();
        res_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        set_all(12'sd0);
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
        n_cmp++;
        if ({busy_o, in_ready_o, res_valid_o, ovf_o} !== 4'b0) begin
            n_bad++;
            $display("FAIL reset_flags got %b want 0000",
                     {busy_o, in_ready_o, res_valid_o, ovf_o});
        end
        n_cmp++;
        if (res_o !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_res got %h want 0", res_o);
        end
    endtask

    task automatic test_single();
        set_all(12'sd1);
        start_job(8'd1);
        n_cmp++;
        if ({busy_o, in_ready_o} !== 2'b11) begin
            n_bad++;
            $display("FAIL single_start got %b want 11",
                     {busy_o, in_ready_o});
        end
        in_valid_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
        for (int i = 1; i < LAT; i++) begin
            n_cmp++;
            if (res_valid_o !== 1'b0) begin
                n_bad++;
                $display("FAIL single_early got %b want 0", res_valid_o);
            end
            tick();
        end
        n_cmp++;
        if (res_valid_o !== 1'b1 || in_ready_o !== 1'b0) begin
            n_bad++;
            $display("FAIL single_lat got v=%b r=%b want v=1 r=0",
                     res_valid_o, in_ready_o);
        end
        n_cmp++;
        if (res_o !== 32'd24 || ovf_o !== 1'b0) begin
            n_bad++;
            $display("FAIL single_res got %0d ovf=%b want 24 ovf=0",
                     $signed(res_o), ovf_o);
        end
        handshake();
        n_cmp++;
        if (busy_o !== 1'b0) begin
            n_bad++;
            $display("FAIL single_idle got busy=%b want 0", busy_o);
        end
    endtask

    task automatic test_negative();
        set_all(12'hFFF);
        start_job(8'd3);
        in_valid_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (res_o !== 32'hFFFF_FFE8 || in_ready_o !== 1'b1) begin
            n_bad++;
            $display("FAIL neg_stall got acc=%h r=%b want ffffffe8 r=1",
                     res_o, in_ready_o);
        end
        in_valid_i = 1'b1;
        tick();
        tick();
        in_valid_i = 1'b0;
        for (int i = 1; i < LAT; i++) tick();
        n_cmp++;
        if (res_valid_o !== 1'b1) begin
            n_bad++;
            $display("FAIL neg_lat got v=%b want 1", res_valid_o);
        end
        n_cmp++;
        if (res_o !== 32'hFFFF_FFB8 || ovf_o !== 1'b0) begin
            n_bad++;
            $display("FAIL neg_res got %h ovf=%b want ffffffb8 ovf=0",
                     res_o, ovf_o);
        end
        handshake();
    endtask

    task automatic test_zero_len();
        set_all(12'sd9);
        start_job(8'd0);
        n_cmp++;
        if ({busy_o, in_ready_o, res_valid_o} !== 3'b101) begin
            n_bad++;
            $display("FAIL zero_flags got %b want 101",
                     {busy_o, in_ready_o, res_valid_o});
        end
        n_cmp++;
        if (res_o !== 32'd0 || ovf_o !== 1'b0) begin
            n_bad++;
            $display("FAIL zero_res got %h ovf=%b want 0 ovf=0", res_o, ovf_o);
        end
        handshake();
        n_cmp++;
        if ({busy_o, in_ready_o} !== 2'b00) begin
            n_bad++;
            $display("FAIL zero_idle got %b want 00", {busy_o, in_ready_o});
        end
    endtask

    task automatic test_backpressure();
        set_all(12'sd5);
        start_job(8'd1);
        in_valid_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
        for (int i = 1; i < LAT; i++) tick();
        for (int c = 0; c < 5; c++) begin
            n_cmp++;
            if (res_valid_o !== 1'b1 || res_o !== 32'd120) begin
                n_bad++;
                $display("FAIL bp_hold[%0d] got v=%b res=%0d want v=1 res=120",
                         c, res_valid_o, res_o);
            end
            start_i = (c == 2);
            len_i   = 8'd2;
            tick();
            start_i = 1'b0;
        end
        handshake();
        n_cmp++;
        if ({busy_o, in_ready_o, res_valid_o} !== 3'b000) begin
            n_bad++;
            $display("FAIL bp_idle got %b want 000",
                     {busy_o, in_ready_o, res_valid_o});
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 24; k++) in_d[k] = 12'(k - 12);
        start_job(8'd2);
        in_valid_i = 1'b1;
        tick();
        set_all(12'sd100);
        tick();
        in_valid_i = 1'b0;
        for (int i = 1; i < LAT; i++) tick();
        n_cmp++;
        if (res_valid_o !== 1'b1 || res_o !== 32'd2388) begin
            n_bad++;
            $display("FAIL b2b_res1 got v=%b res=%0d want v=1 res=2388",
                     res_valid_o, $signed(res_o));
        end
        handshake();
        set_all(12'sd7);
        start_job(8'd1);
        n_cmp++;
        if (in_ready_o !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_restart got r=%b want 1", in_ready_o);
        end
        in_valid_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
        for (int i = 1; i < LAT; i++) tick();
        n_cmp++;
        if (res_valid_o !== 1'b1 || res_o !== 32'd168) begin
            n_bad++;
            $display("FAIL b2b_res2 got v=%b res=%0d want v=1 res=168",
                     res_valid_o, res_o);
        end
        handshake();
    endtask

    task automatic test_overflow();
        set_all(12'sd2047);
        start_job(8'd11);
        in_valid_i = 1'b1;
        repeat (11) tick();
        in_valid_i = 1'b0;
        for (int i = 1; i < LAT; i++) tick();
        n_cmp++;
        if (res_valid2 !== 1'b1 || res2 !== 20'h83EF8 || ovf2 !== 1'b1) begin
            n_bad++;
            $display("FAIL ovf20 got v=%b res=%h ovf=%b want v=1 res=83ef8 ovf=1",
                     res_valid2, res2, ovf2);
        end
        n_cmp++;
        if (res_o !== 32'd540408 || ovf_o !== 1'b0) begin
            n_bad++;
            $display("FAIL ovf32 got res=%0d ovf=%b want 540408 ovf=0",
                     res_o, ovf_o);
        end
        handshake();
        set_all(12'sd1);
        start_job(8'd0);
        n_cmp++;
        if (ovf2 !== 1'b0) begin
            n_bad++;
            $display("FAIL ovf_clear got %b want 0", ovf2);
        end
        handshake();
    endtask

    task automatic test_reset_mid();
        set_all(12'sd3);
        start_job(8'd4);
        in_valid_i = 1'b1;
        tick();
        tick();
        in_valid_i = 1'b0;
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        n_cmp++;
        if ({busy_o, in_ready_o, res_valid_o, ovf_o} !== 4'b0
            || res_o !== 32'd0) begin
            n_bad++;
            $display("FAIL rstmid_outs got flags=%b res=%h want 0000 res=0",
                     {busy_o, in_ready_o, res_valid_o, ovf_o}, res_o);
        end
        set_all(12'sd2);
        start_job(8'd1);
        in_valid_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
        for (int i = 1; i < LAT; i++) tick();
        n_cmp++;
        if (res_valid_o !== 1'b1 || res_o !== 32'd48 || ovf_o !== 1'b0) begin
            n_bad++;
            $display("FAIL rstmid_res got v=%b res=%0d ovf=%b want v=1 48 0",
                     res_valid_o, res_o, ovf_o);
        end
        handshake();
    endtask

    initial begin
        test_reset();
        test_single();
        test_negative();
        test_zero_len();
        test_backpressure();
        test_back_to_back();
        test_overflow();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout after %0d compares", n_cmp);
        $fatal(1, "timeout");
    end

endmodule
